imm_gen_pipe: RTL
=================

Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator, successor to the combinational sign extender.
- Accepts a 32-bit instruction word, an immediate-format select and a sideband tag over a valid/ready handshake.
- Returns the sign-extended immediate at XLEN width, one cycle later, through a 2-entry skid buffer.
- Sits between the decode stage and the execute operand mux, so it can absorb execute-side stalls without dropping decoded immediates.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- TAG_W, 5, width of the sideband tag carried alongside each immediate (e.g. ROB/rd index).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream offers an instruction.
- in_ready  out  1  block can accept this cycle.
- in_instr  in  32  raw instruction word.
- in_imm_src  in  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101 Z (only with the optional feature), others illegal.
- in_tag  in  TAG_W  sideband tag, passed through unchanged.
- out_valid  out  1  output holds a valid immediate.
- out_ready  in  1  downstream accepts this cycle.
- out_imm  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag matching out_imm.
- out_illegal  out  1  in_imm_src was an unsupported code.

Behaviour:
- One clock (clk); reset (rst) is synchronous and active-high.
- Reset values: out_valid=0, out_imm=0, out_tag=0, out_illegal=0. in_ready=1 in the first cycle after rst deasserts.
- Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Latency: an item accepted at edge N is on out_* after edge N (1 cycle). No combinational path from in_* to out_*.
- Storage: main register (drives out_*) plus one skid register. Occupancy states are EMPTY, ONE (main only) and FULL (main + skid).
- in_ready is registered: in_ready = !skid_valid.
- EMPTY + accept -> ONE.
- ONE + accept + out_ready -> ONE (main reloads).
- ONE + accept + !out_ready -> FULL (item goes to skid).
- ONE + no accept + out_ready -> EMPTY.
- FULL + out_ready -> ONE (skid moves to main; in_ready was 0, so no accept).
- FULL + !out_ready -> hold.
- Ordering is strict FIFO; no item is lost or duplicated.
- out_* must stay stable while out_valid && !out_ready.
- Extraction, with s = in_instr[31]; every format sign-extends from bit 31 to XLEN:
  - I: s-ext(instr[31:20]).
  - S: s-ext({instr[31:25], instr[11:7]}).
  - B: s-ext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - J: s-ext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - U: s-ext({instr[31:12], 12'b0}). At XLEN=64 the upper 32 bits copy bit 31 (RV64 LUI semantics).
- Illegal code: out_imm=0, out_illegal=1, tag still passed through; the item still occupies a slot.
- Reset mid-operation: both slots invalidated at the reset edge; in-flight items are discarded, no output is produced for them.
- in_instr, in_imm_src and in_tag are ignored when in_valid=0.

Optional Feature:
- Macro: IMM_GEN_ZIMM_EN.
- Defined: code 101 selects the CSR zimm format, out_imm = zero-extend(instr[19:15]), out_illegal=0.
- Not defined: 101 is illegal (out_imm=0, out_illegal=1).

Decomposition:
- Package imm_gen_pkg holds localparams IMM_I=3'b000, IMM_S=3'b001, IMM_B=3'b010, IMM_J=3'b011, IMM_U=3'b100, IMM_Z=3'b101, plus the XLEN legality check constant.
- Sub-module imm_extract (combinational, XLEN-parametrised) does the format decode and returns {imm, illegal}.
- imm_gen_pipe contains the handshake and skid logic only.

Test Plan:
- XLEN=32, out_ready=1, instr 0xFFF00093, src 000, tag 3 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_tag=3.
- B-type instr 0xFE000EE3, src 010 -> out_imm=0xFFFFFFFC. S-type instr 0x00112623 (sw x1,12(x2)), src 001 -> out_imm=0x0000000C.
- XLEN=64, U-type instr 0x80000037, src 100 -> out_imm=0xFFFFFFFF80000000. J-type instr 0x0040006F -> out_imm=0x4.
- Backpressure: out_ready=0, tags 1,2,3 offered back-to-back -> tags 1,2 accepted and in_ready=0 for tag 3. Release out_ready -> outputs 1,2,3 in order, no duplicates.
- src 111 -> out_imm=0, out_illegal=1. src 101 with instr 0x000AD073 -> 0x15 if IMM_GEN_ZIMM_EN defined, else illegal.
- rst asserted while FULL -> next cycle out_valid=0 and in_ready=1; the first item after reset emerges with correct data.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// ============================================================================
// Module   : imm_gen_pkg
// Purpose  : Shared definitions for the pipelined immediate generator:
//            immediate-format select codes, occupancy encoding of the
//            two-slot output buffer and the XLEN legality check.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package imm_gen_pkg;

    // Immediate-format select codes carried on in_imm_src
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;
    localparam logic [2:0] IMM_Z = 3'b101;

    // Only RV32 and RV64 datapaths are supported
    localparam int unsigned XLEN_LEGAL_A = 32;
    localparam int unsigned XLEN_LEGAL_B = 64;

    function automatic logic xlen_is_legal(input int unsigned xlen);
        return (xlen == XLEN_LEGAL_A) || (xlen == XLEN_LEGAL_B);
    endfunction

    // Occupancy of the main + skid register pair
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

`default_nettype wire

// File: rtl/imm_extract.sv
// ============================================================================
// Module   : imm_extract
// Purpose  : Combinational immediate decoder. Selects one of the RISC-V
//            immediate formats from a 32-bit instruction word and
//            sign-extends it from instruction bit 31 to XLEN bits.
// Ports    : i_instr   [31:0]     raw instruction word
//            i_imm_src [2:0]      format select (I/S/B/J/U, optional Z)
//            o_imm     [XLEN-1:0] extended immediate (0 when illegal)
//            o_illegal            select code not supported
// Macro    : IMM_GEN_ZIMM_EN - when defined, code 101 decodes the CSR zimm
//            field (zero-extended instr[19:15]); otherwise 101 is illegal.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_extract #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    input  logic [2:0]      i_imm_src,
    output logic [XLEN-1:0] o_imm,
    output logic            o_illegal
);
    import imm_gen_pkg::*;

    logic        w_sign;
    logic [31:0] w_imm32;
    logic        w_unused_opcode;

    assign w_sign = i_instr[31];

    // The opcode field never contributes to an immediate
    assign w_unused_opcode = ^i_instr[6:0];

    // Every format is first built as a 32-bit value whose bit 31 is the
    // extension bit; widening to XLEN is then a single signed resize.
    always_comb begin
        w_imm32   = 32'd0;
        o_illegal = 1'b0;
        case (i_imm_src)
            IMM_I: w_imm32 = {{20{w_sign}}, i_instr[31:20]};
            IMM_S: w_imm32 = {{20{w_sign}}, i_instr[31:25], i_instr[11:7]};
            IMM_B: w_imm32 = {{19{w_sign}}, i_instr[31], i_instr[7],
                              i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_J: w_imm32 = {{11{w_sign}}, i_instr[31], i_instr[19:12],
                              i_instr[20], i_instr[30:21], 1'b0};
            IMM_U: w_imm32 = {i_instr[31:12], 12'd0};
`ifdef IMM_GEN_ZIMM_EN
            // zimm is unsigned: bit 31 of the 32-bit value is always 0
            IMM_Z: w_imm32 = {27'd0, i_instr[19:15]};
`endif
            default: o_illegal = 1'b1;
        endcase
    end

    // At XLEN=64 this replicates bit 31 into the upper word (LUI semantics)
    assign o_imm = XLEN'($signed(w_imm32));

endmodule

`default_nettype wire

// File: rtl/imm_gen_pipe.sv
// ============================================================================
// Module   : imm_gen_pipe
// Purpose  : Pipelined immediate generator between decode and the execute
//            operand mux. Decodes one instruction per accepted transfer and
//            presents the XLEN-wide immediate one cycle later through a
//            main register plus a skid register, so execute-side stalls
//            never drop a decoded immediate. Strict FIFO order.
// Ports    : clk, rst                  clock, synchronous active-high reset
//            in_valid / in_ready       upstream handshake (in_ready registered)
//            in_instr [31:0]           instruction word
//            in_imm_src [2:0]          format select
//            in_tag [TAG_W-1:0]        sideband tag, passed through
//            out_valid / out_ready     downstream handshake
//            out_imm [XLEN-1:0]        extended immediate
//            out_tag [TAG_W-1:0]       tag matching out_imm
//            out_illegal               in_imm_src was unsupported
// Macro    : IMM_GEN_ZIMM_EN enables the CSR zimm format (code 101) in the
//            decoder; without it code 101 reports illegal.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);
    import imm_gen_pkg::*;

    generate
        if (!xlen_is_legal(XLEN)) begin : g_xlen_illegal
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    // Decoded view of the incoming instruction
    logic [XLEN-1:0]  w_new_imm;
    logic             w_new_ill;

    // Main slot (drives out_*) and skid slot
    logic             r_main_valid_q, w_main_valid_d;
    logic [XLEN-1:0]  r_main_imm_q,   w_main_imm_d;
    logic [TAG_W-1:0] r_main_tag_q,   w_main_tag_d;
    logic             r_main_ill_q,   w_main_ill_d;
    logic             r_skid_valid_q, w_skid_valid_d;
    logic [XLEN-1:0]  r_skid_imm_q,   w_skid_imm_d;
    logic [TAG_W-1:0] r_skid_tag_q,   w_skid_tag_d;
    logic             r_skid_ill_q,   w_skid_ill_d;

    logic             w_accept;
    occ_e             w_occ;

    imm_extract #(
        .XLEN (XLEN)
    ) u_extract (
        .i_instr   (in_instr),
        .i_imm_src (in_imm_src),
        .o_imm     (w_new_imm),
        .o_illegal (w_new_ill)
    );

    // in_ready comes straight from a flop: the block can always take one
    // more item unless the skid slot is already occupied.
    assign in_ready = ~r_skid_valid_q;
    assign w_accept = in_valid & in_ready;

    // The skid slot is only ever filled behind a valid main slot
    assign w_occ = r_skid_valid_q ? OCC_FULL :
                   r_main_valid_q ? OCC_ONE  : OCC_EMPTY;

    always_comb begin
        w_main_valid_d = r_main_valid_q;
        w_main_imm_d   = r_main_imm_q;
        w_main_tag_d   = r_main_tag_q;
        w_main_ill_d   = r_main_ill_q;
        w_skid_valid_d = r_skid_valid_q;
        w_skid_imm_d   = r_skid_imm_q;
        w_skid_tag_d   = r_skid_tag_q;
        w_skid_ill_d   = r_skid_ill_q;

        case (w_occ)
            OCC_EMPTY: begin
                if (w_accept) begin
                    w_main_valid_d = 1'b1;
                    w_main_imm_d   = w_new_imm;
                    w_main_tag_d   = in_tag;
                    w_main_ill_d   = w_new_ill;
                end
            end
            OCC_ONE: begin
                if (w_accept && out_ready) begin
                    // Current item leaves while the new one replaces it
                    w_main_imm_d   = w_new_imm;
                    w_main_tag_d   = in_tag;
                    w_main_ill_d   = w_new_ill;
                end else if (w_accept) begin
                    // Stalled: park the new item behind the held one
                    w_skid_valid_d = 1'b1;
                    w_skid_imm_d   = w_new_imm;
                    w_skid_tag_d   = in_tag;
                    w_skid_ill_d   = w_new_ill;
                end else if (out_ready) begin
                    w_main_valid_d = 1'b0;
                end
            end
            OCC_FULL: begin
                // in_ready is low here, so nothing new can arrive
                if (out_ready) begin
                    w_main_imm_d   = r_skid_imm_q;
                    w_main_tag_d   = r_skid_tag_q;
                    w_main_ill_d   = r_skid_ill_q;
                    w_skid_valid_d = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid_q <= 1'b0;
            r_main_imm_q   <= '0;
            r_main_tag_q   <= '0;
            r_main_ill_q   <= 1'b0;
            r_skid_valid_q <= 1'b0;
            r_skid_imm_q   <= '0;
            r_skid_tag_q   <= '0;
            r_skid_ill_q   <= 1'b0;
        end else begin
            r_main_valid_q <= w_main_valid_d;
            r_main_imm_q   <= w_main_imm_d;
            r_main_tag_q   <= w_main_tag_d;
            r_main_ill_q   <= w_main_ill_d;
            r_skid_valid_q <= w_skid_valid_d;
            r_skid_imm_q   <= w_skid_imm_d;
            r_skid_tag_q   <= w_skid_tag_d;
            r_skid_ill_q   <= w_skid_ill_d;
        end
    end

    assign out_valid   = r_main_valid_q;
    assign out_imm     = r_main_imm_q;
    assign out_tag     = r_main_tag_q;
    assign out_illegal = r_main_ill_q;

endmodule

`default_nettype wire
